milano_decode_queue: RTL and testbench

MILANO_DECODE_QUEUE -- requirements
Module: milano_decode_queue

---
 rtl/milano_decode_queue.sv | 168 ++++++++++++++++
 tb/tb_milano_decode_queue.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/milano_decode_queue.sv
// Decode queue: decodes fetched RV32 instructions on push and buffers them in a small FIFO.
// Also keeps a saturating count of the illegal instructions it has accepted.
package milano_pkg;
  typedef enum logic [6:0] {
    OPC_LOAD     = 7'h03,
    OPC_MISC_MEM = 7'h0F,
    OPC_OP_IMM   = 7'h13,
    OPC_AUIPC    = 7'h17,
    OPC_STORE    = 7'h23,
    OPC_OP       = 7'h33,
    OPC_LUI      = 7'h37,
    OPC_BRANCH   = 7'h63,
    OPC_JALR     = 7'h67,
    OPC_JAL      = 7'h6F,
    OPC_SYSTEM   = 7'h73
  } opcode_e;
endpackage

module milano_decode_queue
  import milano_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32,
  parameter int RV32E = 0,
  parameter int EN_M  = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [PC_W-1:0] instr_pc_i,
  output logic            dec_valid_o,
  input  logic            dec_ready_i,
  output logic [PC_W-1:0] dec_pc_o,
  output logic [6:0]      dec_opcode_o,
  output logic [4:0]      dec_rd_o,
  output logic [4:0]      dec_rs1_o,
  output logic [4:0]      dec_rs2_o,
  output logic [2:0]      dec_funct3_o,
  output logic [31:0]     dec_imm_o,
  output logic            dec_illegal_o,
  output logic [15:0]     illegal_cnt_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [31:0]     imm;
    logic            illegal;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            dec_entry;
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [15:0]       illegal_cnt;
  logic              push, pop;
  logic              use_rd, use_rs1, use_rs2, bad_opc, bad_f7, bad_reg;

  always_comb begin
    dec_entry        = '0;
    use_rd           = 1'b0;
    use_rs1          = 1'b0;
    use_rs2          = 1'b0;
    bad_opc          = 1'b0;
    bad_f7           = 1'b0;
    dec_entry.pc     = instr_pc_i;
    dec_entry.opcode = instr_i[6:0];
    dec_entry.rd     = instr_i[11:7];
    dec_entry.rs1    = instr_i[19:15];
    dec_entry.rs2    = instr_i[24:20];
    dec_entry.funct3 = instr_i[14:12];
    case (instr_i[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: begin
        dec_entry.imm = {{20{instr_i[31]}}, instr_i[31:20]};
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        dec_entry.imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        dec_entry.imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_entry.imm = {instr_i[31:12], 12'h000};
        use_rd = 1'b1;
      end
      OPC_JAL: begin
        dec_entry.imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
        use_rd = 1'b1;
      end
      OPC_OP: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        bad_f7  = !((instr_i[31:25] == 7'h00) || (instr_i[31:25] == 7'h20) ||
                    ((EN_M != 0) && (instr_i[31:25] == 7'h01)));
      end
      default: bad_opc = 1'b1;
    endcase
    // RV32E only has x0..x15, so bit 4 of any used register index is illegal
    bad_reg = (RV32E != 0) && ((use_rd && instr_i[11]) || (use_rs1 && instr_i[19]) ||
                               (use_rs2 && instr_i[24]));
    dec_entry.illegal = (instr_i[1:0] != 2'b11) || bad_opc || bad_f7 || bad_reg;
  end

  assign instr_ready_o = rst_ni && (count < CNT_W'(DEPTH)) && !flush_i;
  assign dec_valid_o   = (count != '0);
  assign push          = instr_valid_i && instr_ready_o;
  assign pop           = dec_valid_o && dec_ready_i && !flush_i;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      illegal_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec_entry;
        wr_ptr      <= ptr_inc(wr_ptr);
        if (dec_entry.illegal && (illegal_cnt != 16'hFFFF)) illegal_cnt <= illegal_cnt + 16'd1;
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head          = mem[rd_ptr];
  assign dec_pc_o      = head.pc;
  assign dec_opcode_o  = head.opcode;
  assign dec_rd_o      = head.rd;
  assign dec_rs1_o     = head.rs1;
  assign dec_rs2_o     = head.rs2;
  assign dec_funct3_o  = head.funct3;
  assign dec_imm_o     = head.imm;
  assign dec_illegal_o = head.illegal;
  assign illegal_cnt_o = illegal_cnt;
endmodule

// File: tb/tb_milano_decode_queue.sv
// Bench for milano_decode_queue: a base instance and an RV32E+M instance share stimulus
// and are compared every cycle against a queue-based reference model.
module tb_milano_decode_queue;
  logic        clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0;
  logic        instr_valid_i = 1'b0, dec_ready_i = 1'b0;
  logic [31:0] instr_i = '0, instr_pc_i = '0;

  logic        a_ready, a_dvalid, a_ill, b_ready, b_dvalid, b_ill;
  logic [31:0] a_pc, a_imm, b_pc, b_imm;
  logic [6:0]  a_opc, b_opc;
  logic [4:0]  a_rd, a_rs1, a_rs2, b_rd, b_rs1, b_rs2;
  logic [2:0]  a_f3, b_f3;
  logic [15:0] a_cnt, b_cnt;

  milano_decode_queue u_dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(a_ready), .instr_i(instr_i), .instr_pc_i(instr_pc_i),
    .dec_valid_o(a_dvalid), .dec_ready_i(dec_ready_i), .dec_pc_o(a_pc),
    .dec_opcode_o(a_opc), .dec_rd_o(a_rd), .dec_rs1_o(a_rs1), .dec_rs2_o(a_rs2),
    .dec_funct3_o(a_f3), .dec_imm_o(a_imm), .dec_illegal_o(a_ill), .illegal_cnt_o(a_cnt));

  milano_decode_queue #(.RV32E(1), .EN_M(1)) u_dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(b_ready), .instr_i(instr_i), .instr_pc_i(instr_pc_i),
    .dec_valid_o(b_dvalid), .dec_ready_i(dec_ready_i), .dec_pc_o(b_pc),
    .dec_opcode_o(b_opc), .dec_rd_o(b_rd), .dec_rs1_o(b_rs1), .dec_rs2_o(b_rs2),
    .dec_funct3_o(b_f3), .dec_imm_o(b_imm), .dec_illegal_o(b_ill), .illegal_cnt_o(b_cnt));

  always #5 clk_i = ~clk_i;

  localparam int DEPTH = 2;
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] mq_w[$], mq_pc[$];
  int          cnt_a = 0, cnt_b = 0;
  logic [6:0]  opc_tab [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63,
                                7'h67, 7'h6F, 7'h73};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference decoder from the ISA rules: immediate by format, legality by opcode/funct7/regs.
  function automatic void ref_dec(input logic [31:0] w, input bit e, input bit m,
                                  output logic [31:0] imm, output bit ill);
    bit ur = 0, u1 = 0, u2 = 0;
    imm = '0;
    ill = (w[1:0] != 2'b11);
    case (w[6:0])
      7'h03, 7'h0F, 7'h13, 7'h67, 7'h73: begin
        imm = 32'($signed(w[31:20])); ur = 1; u1 = 1;
      end
      7'h23: begin imm = 32'($signed({w[31:25], w[11:7]})); u1 = 1; u2 = 1; end
      7'h63: begin
        imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})); u1 = 1; u2 = 1;
      end
      7'h37, 7'h17: begin imm = {w[31:12], 12'h000}; ur = 1; end
      7'h6F: begin imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); ur = 1; end
      7'h33: begin
        ur = 1; u1 = 1; u2 = 1;
        if (!(w[31:25] inside {7'h00, 7'h20} || (m && w[31:25] == 7'h01))) ill = 1;
      end
      default: ill = 1;
    endcase
    if (e && ((ur && w[11]) || (u1 && w[19]) || (u2 && w[24]))) ill = 1;
  endfunction

  task automatic check_outputs();
    logic [31:0] w, imm;
    bit ill;
    chk("a_ready", a_ready, (mq_w.size() < DEPTH) && !flush_i);
    chk("b_ready", b_ready, (mq_w.size() < DEPTH) && !flush_i);
    chk("a_valid", a_dvalid, mq_w.size() != 0);
    chk("b_valid", b_dvalid, mq_w.size() != 0);
    chk("a_cnt", a_cnt, cnt_a);
    chk("b_cnt", b_cnt, cnt_b);
    if (mq_w.size() != 0) begin
      w = mq_w[0];
      ref_dec(w, 0, 0, imm, ill);
      chk("a_fields", {a_opc, a_rd, a_rs1, a_rs2, a_f3},
          {w[6:0], w[11:7], w[19:15], w[24:20], w[14:12]});
      chk("a_imm", a_imm, imm);
      chk("a_ill", a_ill, ill);
      chk("a_pc", a_pc, mq_pc[0]);
      ref_dec(w, 1, 1, imm, ill);
      chk("b_fields", {b_opc, b_rd, b_rs1, b_rs2, b_f3},
          {w[6:0], w[11:7], w[19:15], w[24:20], w[14:12]});
      chk("b_imm", b_imm, imm);
      chk("b_ill", b_ill, ill);
      chk("b_pc", b_pc, mq_pc[0]);
    end
  endtask

  // Called just after a falling edge with inputs set; checks, then advances one clock.
  task automatic tick();
    bit do_push, do_pop, ill;
    logic [31:0] imm;
    #1 check_outputs();
    do_push = instr_valid_i && (mq_w.size() < DEPTH) && !flush_i;
    do_pop  = dec_ready_i && (mq_w.size() != 0) && !flush_i;
    @(posedge clk_i);
    if (flush_i) begin
      mq_w.delete();
      mq_pc.delete();
    end else begin
      if (do_pop) begin
        void'(mq_w.pop_front());
        void'(mq_pc.pop_front());
      end
      if (do_push) begin
        mq_w.push_back(instr_i);
        mq_pc.push_back(instr_pc_i);
        ref_dec(instr_i, 0, 0, imm, ill);
        if (ill && cnt_a < 65535) cnt_a++;
        ref_dec(instr_i, 1, 1, imm, ill);
        if (ill && cnt_b < 65535) cnt_b++;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic push_one(input logic [31:0] w, input logic [31:0] pc);
    instr_valid_i = 1'b1; instr_i = w; instr_pc_i = pc;
    tick();
    instr_valid_i = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    int sel = $urandom_range(0, 9);
    if (sel < 8) w[6:0] = opc_tab[$urandom_range(0, 10)];
    if (w[6:0] == 7'h33) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    return w;
  endfunction

  initial begin
    int saved_a, saved_b;
    #1;
    chk("rst_ready", {a_ready, b_ready}, 2'b00);
    chk("rst_valid", {a_dvalid, b_dvalid}, 2'b00);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_data", {a_pc, a_imm, a_ill}, 65'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // addi x1,x0,5
    dec_ready_i = 1'b1;
    push_one(32'h00500093, 32'h100);
    #1;
    chk("addi_opc", a_opc, 7'h13);
    chk("addi_rd", a_rd, 5'd1);
    chk("addi_imm", a_imm, 32'h5);
    chk("addi_ill", a_ill, 1'b0);
    tick();

    // lui then beq -4, back to back
    dec_ready_i = 1'b0;
    push_one(32'h12345137, 32'h104);
    push_one(32'hFE000EE3, 32'h108);
    #1 chk("lui_imm", a_imm, 32'h12345000);
    dec_ready_i = 1'b1;
    tick();
    #1 chk("beq_imm", a_imm, 32'hFFFFFFFC);
    tick();

    // all-zero word is illegal and counted
    push_one(32'h0, 32'h10C);
    #1;
    chk("zero_ill", a_ill, 1'b1);
    chk("zero_cnt", a_cnt, 16'd1);
    tick();
    push_one(32'h01000093, 32'h110);
    #1 chk("e_legal", b_ill, 1'b0);
    tick();
    push_one(32'h00000893, 32'h114);
    #1;
    chk("e_rd17_ill", b_ill, 1'b1);
    chk("base_rd17_ok", a_ill, 1'b0);
    tick();

    // full queue back-pressure and FIFO order
    dec_ready_i = 1'b0;
    push_one(32'h00100113, 32'h200);
    push_one(32'h00200193, 32'h204);
    instr_valid_i = 1'b1; instr_i = 32'h00300213; instr_pc_i = 32'h208;
    #1 chk("full_ready", a_ready, 1'b0);
    tick();
    dec_ready_i = 1'b1;
    tick();
    dec_ready_i = 1'b0;
    tick();
    instr_valid_i = 1'b0;
    #1 chk("after_pop_head_pc", a_pc, 32'h204);
    dec_ready_i = 1'b1;
    tick();
    tick();

    // flush on a full queue, with an illegal word offered
    dec_ready_i = 1'b0;
    push_one(32'h00400293, 32'h300);
    push_one(32'h00500313, 32'h304);
    saved_a = cnt_a; saved_b = cnt_b;
    flush_i = 1'b1; instr_valid_i = 1'b1; instr_i = 32'h0;
    tick();
    flush_i = 1'b0; instr_valid_i = 1'b0;
    #1;
    chk("flush_valid", a_dvalid, 1'b0);
    chk("flush_cnt_a", a_cnt, saved_a);
    chk("flush_cnt_b", b_cnt, saved_b);
    tick();

    for (int i = 0; i < 3000; i++) begin
      instr_valid_i = ($urandom_range(0, 3) != 0);
      dec_ready_i   = ($urandom_range(0, 2) != 0);
      flush_i       = ($urandom_range(0, 31) == 0);
      instr_i       = rand_instr();
      instr_pc_i    = $urandom;
      tick();
    end
    flush_i = 1'b0; instr_valid_i = 1'b0; dec_ready_i = 1'b0;
    tick();

    // async reset with two queued entries
    push_one(32'h00600393, 32'h400);
    push_one(32'h00000000, 32'h404);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_valid", {a_dvalid, b_dvalid}, 2'b00);
    chk("arst_cnt", {a_cnt, b_cnt}, 32'd0);
    chk("arst_ready", a_ready, 1'b0);
    chk("arst_data", {a_pc, a_imm}, 64'd0);
    mq_w.delete(); mq_pc.delete(); cnt_a = 0; cnt_b = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    dec_ready_i = 1'b1;
    push_one(32'h00700413, 32'h500);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
